// File: rtl/mem_byte_lsu.sv
// rtl/mem_byte_lsu.sv - byte-serial RV32I memory-stage load/store unit
// Define MEM_MISALIGN_CHK_EN to reject misaligned halfword/word accesses.
module mem_byte_lsu #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [MEM_ADDR_W-1:0] in_addr,
  input  logic [31:0]           in_sdata,
  input  logic [31:0]           in_alu,
  input  logic                  in_wreg,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic [31:0]           wb_wdata,
  output logic                  misalign
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_cnt;
  logic [1:0]              r_nm1;
  logic                    r_issued;
  logic                    r_pend;
  logic [1:0]              r_pidx;
  logic [MEM_ADDR_W-1:0]   r_base;
  logic [3:0]              r_op;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic                    r_wreg;
  logic [31:0]             r_data;
  logic                    r_wb_we;
  logic [REG_ADDR_W-1:0]   r_wb_waddr;
  logic [31:0]             r_wb_wdata;
  logic                    r_misalign;

  logic                    w_accept;
  logic                    w_is_load;
  logic                    w_is_store;
  logic [1:0]              w_nm1;
  logic                    w_misal;
  logic [31:0]             w_ld_word;
  logic [31:0]             w_ld_ext;
  logic                    w_mem_req;
  logic                    w_mem_wr;
  logic [MEM_ADDR_W-1:0]   w_mem_addr;
  logic [7:0]              w_mem_dout;

  assign in_ready   = (r_state == S_IDLE);
  assign w_accept   = in_valid & in_ready;
  assign w_is_load  = (in_op >= OP_LB) && (in_op <= OP_LHU);
  assign w_is_store = (in_op >= OP_SB) && (in_op <= OP_SW);

  // Last byte index (N-1) for the incoming op.
  always_comb begin
    w_nm1 = 2'd0;
    case (in_op)
      OP_LH, OP_LHU, OP_SH: w_nm1 = 2'd1;
      OP_LW, OP_SW:         w_nm1 = 2'd3;
      default:              w_nm1 = 2'd0;
    endcase
  end

`ifdef MEM_MISALIGN_CHK_EN
  assign w_misal = ((in_op == OP_LH || in_op == OP_LHU || in_op == OP_SH) && in_addr[0]) ||
                   ((in_op == OP_LW || in_op == OP_SW) && (in_addr[1:0] != 2'b00));
`else
  assign w_misal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_misal) begin
          if (w_is_load) begin
            w_state_nxt = S_LOAD;
          end else if (w_is_store) begin
            w_state_nxt = S_STORE;
          end
        end
      end
      S_LOAD:  if (r_issued) w_state_nxt = S_IDLE;
      S_STORE: if (r_cnt == r_nm1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Memory port is a pure decode of registered state, so it never glitches on EX inputs.
  always_comb begin
    w_mem_req  = 1'b0;
    w_mem_wr   = 1'b0;
    w_mem_addr = '0;
    w_mem_dout = 8'h00;
    case (r_state)
      S_LOAD: begin
        if (!r_issued) begin
          w_mem_req  = 1'b1;
          w_mem_addr = r_base + {{(MEM_ADDR_W-2){1'b0}}, r_cnt};
        end
      end
      S_STORE: begin
        w_mem_req  = 1'b1;
        w_mem_wr   = 1'b1;
        w_mem_addr = r_base + {{(MEM_ADDR_W-2){1'b0}}, r_cnt};
        w_mem_dout = r_data[{r_cnt, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_ld_word = r_data;
    w_ld_word[{r_pidx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    w_ld_ext = w_ld_word;
    case (r_op)
      OP_LB:   w_ld_ext = {{24{w_ld_word[7]}}, w_ld_word[7:0]};
      OP_LH:   w_ld_ext = {{16{w_ld_word[15]}}, w_ld_word[15:0]};
      OP_LBU:  w_ld_ext = {24'd0, w_ld_word[7:0]};
      OP_LHU:  w_ld_ext = {16'd0, w_ld_word[15:0]};
      default: w_ld_ext = w_ld_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 2'd0;
      r_nm1      <= 2'd0;
      r_issued   <= 1'b0;
      r_pend     <= 1'b0;
      r_pidx     <= 2'd0;
      r_base     <= '0;
      r_op       <= 4'd0;
      r_rd       <= '0;
      r_wreg     <= 1'b0;
      r_data     <= 32'd0;
      r_wb_we    <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_wdata <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      r_wb_we    <= 1'b0;
      r_misalign <= 1'b0;
      if (w_accept) begin
        r_base   <= in_addr;
        r_op     <= in_op;
        r_rd     <= in_rd;
        r_wreg   <= in_wreg;
        r_nm1    <= w_nm1;
        r_cnt    <= 2'd0;
        r_issued <= 1'b0;
        r_pend   <= 1'b0;
        r_pidx   <= 2'd0;
        r_data   <= w_is_store ? in_sdata : 32'd0;
        if (w_misal) begin
          r_misalign <= 1'b1;
        end else if (!w_is_load && !w_is_store && in_wreg && (in_rd != '0)) begin
          r_wb_we    <= 1'b1;
          r_wb_waddr <= in_rd;
          r_wb_wdata <= in_alu;
        end
      end else if (r_state == S_LOAD) begin
        // A byte requested this cycle arrives on mem_din next cycle.
        r_pend <= !r_issued;
        r_pidx <= r_cnt;
        if (!r_issued) begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == r_nm1) begin
            r_issued <= 1'b1;
          end
        end
        if (r_pend) begin
          r_data <= w_ld_word;
        end
        if (r_issued && r_wreg && (r_rd != '0)) begin
          r_wb_we    <= 1'b1;
          r_wb_waddr <= r_rd;
          r_wb_wdata <= w_ld_ext;
        end
      end else if (r_state == S_STORE) begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  assign mem_req  = w_mem_req;
  assign mem_wr   = w_mem_wr;
  assign mem_addr = w_mem_addr;
  assign mem_dout = w_mem_dout;
  assign wb_we    = r_wb_we;
  assign wb_waddr = r_wb_waddr;
  assign wb_wdata = r_wb_wdata;
  assign misalign = r_misalign;

endmodule
